// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths and the write-back control bundle
// carried from the M stage into the W stage.
package cpu_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic              regw;
    logic              memtoreg;
    logic [ADDR_W-1:0] a3;
  } wb_ctrl_t;
endpackage

// File: rtl/wb_regfile_if.sv
// M-stage to W-stage write-back bus: control, destination, data and trace PC.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);
  logic              regwM;
  logic              memtoregM;
  logic              flushM;
  logic [ADDR_W-1:0] a3M;
  logic [DATA_W-1:0] aluoutM;
  logic [DATA_W-1:0] rdataM;
  logic [31:0]       pcM;

  modport master (output regwM, memtoregM, flushM, a3M, aluoutM, rdataM, pcM);
  modport slave  (input  regwM, memtoregM, flushM, a3M, aluoutM, rdataM, pcM);
endinterface

// File: rtl/wb_regfile_grf.sv
// General register file: async-cleared array, register 0 reads as zero,
// two read ports bypassing the write issued in the same cycle.
module grf #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [NREG];
  logic              wrEn;

  assign wrEn = we && (wa != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wrEn) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = (a1 == '0) ? '0 : (wrEn && a1 == wa) ? wd : rf[a1];
  assign rd2 = (a2 == '0) ? '0 : (wrEn && a2 == wa) ? wd : rf[a2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: W pipeline register, write-back mux, commit trace and
// commit counter in front of the general register file.
module wb_regfile #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  wb_regfile_if.slave       mStage,
  input  logic [ADDR_W-1:0] a1D,
  input  logic [ADDR_W-1:0] a2D,
  output logic [DATA_W-1:0] rd1D,
  output logic [DATA_W-1:0] rd2D,
  output logic [ADDR_W-1:0] a3W,
  output logic [DATA_W-1:0] wdW,
  output logic              regwW,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W-1:0] trace_reg,
  output logic [DATA_W-1:0] trace_data,
  output logic [31:0]       commit_cnt
);
  import cpu_pkg::*;

  wb_ctrl_t          ctrlW;
  logic [DATA_W-1:0] aluoutW;
  logic [DATA_W-1:0] rdataW;
  logic [31:0]       pcW;
  logic [31:0]       commitCnt;
  logic              commit;

  // A flushed M instruction enters W as a bubble; the rest of W is captured as-is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrlW   <= '0;
      aluoutW <= '0;
      rdataW  <= '0;
      pcW     <= '0;
    end else begin
      ctrlW.regw     <= mStage.regwM & ~mStage.flushM;
      ctrlW.memtoreg <= mStage.memtoregM;
      ctrlW.a3       <= mStage.a3M;
      aluoutW        <= mStage.aluoutM;
      rdataW         <= mStage.rdataM;
      pcW            <= mStage.pcM;
    end
  end

  assign commit = ctrlW.regw && (ctrlW.a3 != ADDR_W'(REG_ZERO));
  assign wdW    = ctrlW.memtoreg ? rdataW : aluoutW;
  assign regwW  = commit;
  assign a3W    = commit ? ctrlW.a3 : '0;

  assign trace_valid = commit;
  assign trace_pc    = commit ? pcW : '0;
  assign trace_reg   = commit ? ctrlW.a3 : '0;
  assign trace_data  = commit ? wdW : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) commitCnt <= '0;
    else if (commit) commitCnt <= commitCnt + 32'd1;
  end
  assign commit_cnt = commitCnt;

  grf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uGrf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (regwW),
    .wa      (a3W),
    .wd      (wdW),
    .a1      (a1D),
    .a2      (a2D),
    .rd1     (rd1D),
    .rd2     (rd2D)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected W contents are queued as M inputs
// are driven and checked, with a reference register file, one edge later.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  a1D, a2D, a3W, trace_reg;
  logic [31:0] rd1D, rd2D, wdW, trace_pc, trace_data, commit_cnt;
  logic        regwW, trace_valid;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) mIf ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mStage      (mIf),
    .a1D         (a1D),
    .a2D         (a2D),
    .rd1D        (rd1D),
    .rd2D        (rd2D),
    .a3W         (a3W),
    .wdW         (wdW),
    .regwW       (regwW),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_reg   (trace_reg),
    .trace_data  (trace_data),
    .commit_cnt  (commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        commit;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wexp_t;

  wexp_t       sbq[$];
  wexp_t       curW;
  logic [31:0] mRf [32];
  logic [31:0] mCnt;
  int          nTests = 0;
  int          nFail  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) mRf[i] = '0;
    mCnt = '0;
    curW = '{commit: 1'b0, a3: 5'd0, wd: 32'd0, pc: 32'd0};
    sbq.delete();
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, ".regwW"},      {31'd0, regwW}, 32'd0);
    checkVal({tag, ".a3W"},        {27'd0, a3W}, 32'd0);
    checkVal({tag, ".wdW"},        wdW, 32'd0);
    checkVal({tag, ".traceValid"}, {31'd0, trace_valid}, 32'd0);
    checkVal({tag, ".tracePc"},    trace_pc, 32'd0);
    checkVal({tag, ".traceReg"},   {27'd0, trace_reg}, 32'd0);
    checkVal({tag, ".traceData"},  trace_data, 32'd0);
    checkVal({tag, ".commitCnt"},  commit_cnt, 32'd0);
    checkVal({tag, ".rd1D"},       rd1D, 32'd0);
    checkVal({tag, ".rd2D"},       rd2D, 32'd0);
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (curW.commit && a == curW.a3) return curW.wd;
    return mRf[a];
  endfunction

  task automatic step(input string tag, input logic regw, input logic mtr,
                      input logic [4:0] a3, input logic [31:0] alu, input logic [31:0] rdata,
                      input logic [31:0] pc, input logic flush,
                      input logic [4:0] a1, input logic [4:0] a2);
    wexp_t e;
    mIf.regwM = regw; mIf.memtoregM = mtr; mIf.a3M = a3; mIf.aluoutM = alu;
    mIf.rdataM = rdata; mIf.pcM = pc; mIf.flushM = flush;
    a1D = a1; a2D = a2;
    e.commit = regw && !flush && (a3 != 5'd0);
    e.a3     = e.commit ? a3 : 5'd0;
    e.wd     = mtr ? rdata : alu;
    e.pc     = pc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    // The W entry that was current before this edge commits on it.
    if (curW.commit) begin
      mRf[curW.a3] = curW.wd;
      mCnt = mCnt + 32'd1;
    end
    checkVal({tag, ".sbq"}, sbq.size(), 32'd1);
    if (sbq.size() > 0) curW = sbq.pop_front();
    checkVal({tag, ".regwW"},      {31'd0, regwW}, {31'd0, curW.commit});
    checkVal({tag, ".a3W"},        {27'd0, a3W}, {27'd0, curW.a3});
    checkVal({tag, ".wdW"},        wdW, curW.wd);
    checkVal({tag, ".traceValid"}, {31'd0, trace_valid}, {31'd0, curW.commit});
    checkVal({tag, ".tracePc"},    trace_pc, curW.commit ? curW.pc : 32'd0);
    checkVal({tag, ".traceReg"},   {27'd0, trace_reg}, {27'd0, curW.a3});
    checkVal({tag, ".traceData"},  trace_data, curW.commit ? curW.wd : 32'd0);
    checkVal({tag, ".commitCnt"},  commit_cnt, mCnt);
    checkVal({tag, ".rd1D"},       rd1D, expRead(a1));
    checkVal({tag, ".rd2D"},       rd2D, expRead(a2));
  endtask

  task automatic bubble(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    step(tag, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, a1, a2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    resetModel();
    for (int c = 0; c < 3; c++) begin
      mIf.regwM = 1'b1; mIf.memtoregM = 1'($urandom); mIf.flushM = 1'b0;
      mIf.a3M = 5'($urandom_range(1, 31)); mIf.aluoutM = $urandom; mIf.rdataM = $urandom;
      mIf.pcM = $urandom; a1D = 5'($urandom); a2D = 5'($urandom);
      @(posedge clk);
      #1;
      checkZero("rstHold");
    end
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) bubble("postRst", 5'(i), 5'(31 - i));

    step("aluWr", 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'hAAAA_5555, 32'h0000_0100, 1'b0, 5'd5, 5'd5);
    bubble("aluRf", 5'd5, 5'd0);

    step("load", 1'b1, 1'b1, 5'd8, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0104, 1'b0, 5'd8, 5'd5);
    bubble("loadRf", 5'd8, 5'd5);

    step("zeroWr", 1'b1, 1'b0, 5'd0, 32'h0000_FFFF, 32'd0, 32'h0000_0108, 1'b0, 5'd0, 5'd3);
    step("flush", 1'b1, 1'b0, 5'd3, 32'h0000_0333, 32'd0, 32'h0000_010C, 1'b1, 5'd0, 5'd3);
    bubble("zeroFlushRf", 5'd0, 5'd3);

    step("b2b1", 1'b1, 1'b0, 5'd7, 32'd1, 32'd0, 32'h0000_0110, 1'b0, 5'd8, 5'd7);
    step("b2b2", 1'b1, 1'b0, 5'd7, 32'd2, 32'd0, 32'h0000_0114, 1'b0, 5'd8, 5'd7);
    step("b2b3", 1'b1, 1'b0, 5'd7, 32'd3, 32'd0, 32'h0000_0118, 1'b0, 5'd8, 5'd7);
    bubble("b2bRf", 5'd5, 5'd7);

    for (int k = 0; k < 8; k++)
      step("rand", 1'b1, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom));
    bubble("randRf", 5'd7, 5'd8);

    step("preRst", 1'b1, 1'b0, 5'd9, 32'h0000_0055, 32'd0, 32'h0000_0200, 1'b0, 5'd9, 5'd9);
    #1 reset_n = 1'b0;
    #1 checkZero("midRst");
    #3 reset_n = 1'b1;
    resetModel();
    bubble("postMidRst", 5'd9, 5'd5);
    bubble("postMidRst2", 5'd9, 5'd7);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
